countdown_tick_ctrl: RTL

//   Control end of the countdown-timer interface. Divides the system clock into a one-cycle

---
 rtl/countdown_tick_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/countdown_tick_ctrl.sv
// countdown_tick_ctrl: tick prescaler, load strobe and run-state FSM that
// drive an external countdown timer, plus a low-time warning flag.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   start        pulse: load the timer and (re)start running
//   pause        pulse: toggle RUNNING <-> PAUSED
//   timer_done   timer has reached zero
//   current_time timer count, TIMER_BITS wide
//   tick_en      one-cycle enable pulse to the timer, every DIV cycles
//   timer_load_n active-low one-cycle load strobe to the timer
//   state        00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED
//   expired      high while in EXPIRED
//   warn         high while 0 < current_time <= WARN_TIME (registered)
//
// Build option: define WARN_BLINK_EN to make warn blink at TICK_HZ with a
// 50% duty cycle (high for the lower half of the prescaler count).
module countdown_tick_ctrl #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 1,
    parameter int TIMER_BITS = 6,
    parameter int WARN_TIME  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  timer_done,
    input  logic [TIMER_BITS-1:0] current_time,
    output logic                  tick_en,
    output logic                  timer_load_n,
    output logic [1:0]            state,
    output logic                  expired,
    output logic                  warn
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);

    localparam logic [PW-1:0]         LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0]         HALF   = PW'(DIV / 2);
    localparam logic [TIMER_BITS-1:0] WARN_T = TIMER_BITS'(WARN_TIME);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        EXPIRED = 2'b11
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_q;
    logic          tick_d;
    logic          load_n_q;
    logic          load_n_d;
    logic          guard_q;
    logic          warn_q;
    logic          warn_d;
    logic          expired_q;
    logic          done_ok;
    logic          in_window;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            load_n_q  <= 1'b0;
            guard_q   <= 1'b1;
            warn_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            load_n_q  <= load_n_d;
            // Marks the cycle right after a load strobe.
            guard_q   <= !load_n_q;
            warn_q    <= warn_d;
            expired_q <= (state_d == EXPIRED);
        end
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;
        load_n_d = 1'b1;
        // The timer still shows its old zero during the load cycle and
        // the one after it, so timer_done is not trusted there.
        done_ok  = timer_done && load_n_q && !guard_q;

        if (start) begin
            state_d  = RUNNING;
            presc_d  = '0;
            load_n_d = 1'b0;
        end else begin
            unique case (state_q)
                RUNNING: begin
                    if (done_ok) begin
                        state_d = EXPIRED;
                    end else if (pause) begin
                        state_d = PAUSED;
                    end
                end
                PAUSED: begin
                    if (pause) begin
                        state_d = RUNNING;
                    end
                end
                default: begin
                end
            endcase

            // Count only into running cycles: a pause freezes the count
            // and a resume picks it up, stretching the interval exactly.
            if (state_d == RUNNING) begin
                if (presc_q == LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end else if (state_d == EXPIRED) begin
                presc_d = '0;
            end
        end

        in_window = (state_q == RUNNING || state_q == PAUSED)
                    && current_time != '0
                    && current_time <= WARN_T;
`ifdef WARN_BLINK_EN
        warn_d = in_window && (presc_q < HALF);
`else
        warn_d = in_window;
`endif
    end

    assign tick_en      = tick_q;
    assign timer_load_n = load_n_q;
    assign state        = state_q;
    assign expired      = expired_q;
    assign warn         = warn_q;

endmodule
